ad9122_cfg_seq: RTL

Configuration sequencer and arbiter in front of the AD9122 SPI engine.
- After `start`, it walks a register table of NUM_ENTRIES (addr, data) pairs and issues one SPI write per entry to the engine.
- Between entries it waits for the engine's done pulse plus a settle gap.
- Once init is done, it shares the engine with a host single-access port (read or write).
- It sits between the board-level init/control logic and the SPI engine.

---
 rtl/ad9122_cfg_seq_if.sv | 23 ++
 rtl/ad9122_cfg_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9122_cfg_seq_if.sv
// Request/response bus between the configuration sequencer and the AD9122 SPI engine.
// Latency: none, wires only.
// Backpressure: none on the bus; the sequencer keeps at most one request outstanding until spi_done.
// Ports: spi_addr, spi_wdata, spi_wr_req, spi_rd_req (sequencer -> engine);
//        spi_rdata, spi_done (engine -> sequencer). master = sequencer, slave = engine.
interface ad9122_cfg_seq_if;
  logic [7:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_wr_req;
  logic       spi_rd_req;
  logic [7:0] spi_rdata;
  logic       spi_done;

  modport master (
    output spi_addr, spi_wdata, spi_wr_req, spi_rd_req,
    input  spi_rdata, spi_done
  );

  modport slave (
    input  spi_addr, spi_wdata, spi_wr_req, spi_rd_req,
    output spi_rdata, spi_done
  );
endinterface

// File: rtl/ad9122_cfg_seq.sv
// AD9122 init-table sequencer plus host single-access arbiter in front of the SPI engine.
// Latency: first engine request 2 cycles after start; SETTLE_CYC+2 cycles from spi_done to the next request.
// Backpressure: one engine request outstanding at a time; host_req is held off while init runs.
// Ports: clk/rst; start; tbl_idx -> ROM, tbl_addr/tbl_data <- ROM (combinational);
//        host_req/host_wr/host_addr/host_wdata in, host_ack/host_rdata out;
//        spi (ad9122_cfg_seq_if.master) to the engine; busy/init_done/err/err_idx status.
// Option: define AD9122_CFG_VERIFY_EN to read back every table write and retry on mismatch.
module ad9122_cfg_seq #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_addr,
  input  logic [7:0]       tbl_data,
  input  logic             host_req,
  input  logic             host_wr,
  input  logic [7:0]       host_addr,
  input  logic [7:0]       host_wdata,
  output logic             host_ack,
  output logic [7:0]       host_rdata,
  ad9122_cfg_seq_if.master spi,
  output logic             busy,
  output logic             init_done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > 256 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1 ||
      MAX_RETRY < 0 || (1 << IDX_W) < NUM_ENTRIES) begin : g_cfg_check
    $error("ad9122_cfg_seq: illegal parameter set");
  end

  typedef enum logic [3:0] {
    IDLE, ISSUE, WAIT, GAP, HOST_ISSUE, HOST_WAIT, DONE, ERR
`ifdef AD9122_CFG_VERIFY_EN
    , VERIFY_ISSUE, VERIFY_WAIT
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_nxt, err_idx_nxt;
  logic             in_host, in_host_nxt;   // GAP belongs to a host access, not a table entry
  logic             host_wr_q, host_wr_nxt;
  logic [7:0]       addr_nxt, wdata_nxt, rdata_nxt;
  logic             wr_req_nxt, rd_req_nxt, ack_nxt, init_done_nxt, err_nxt;
  logic             last_entry, timed_out;
`ifdef AD9122_CFG_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry, retry_nxt;
`endif

  assign last_entry = (tbl_idx == IDX_W'(NUM_ENTRIES - 1));
  assign timed_out  = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = tbl_idx;
    in_host_nxt   = in_host;
    host_wr_nxt   = host_wr_q;
    addr_nxt      = spi.spi_addr;
    wdata_nxt     = spi.spi_wdata;
    wr_req_nxt    = 1'b0;
    rd_req_nxt    = 1'b0;
    ack_nxt       = 1'b0;
    rdata_nxt     = host_rdata;
    init_done_nxt = init_done;
    err_nxt       = err;
    err_idx_nxt   = err_idx;
`ifdef AD9122_CFG_VERIFY_EN
    retry_nxt     = retry;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = ISSUE;
          idx_nxt       = '0;
          init_done_nxt = 1'b0;
          err_nxt       = 1'b0;
`ifdef AD9122_CFG_VERIFY_EN
          retry_nxt     = '0;
`endif
        end else if (host_req && !host_ack) begin
          // host_ack is still high in the cycle a timed-out access returns here;
          // the old request level must not start a second access.
          state_nxt = HOST_ISSUE;
        end
      end
      ISSUE: begin
        addr_nxt    = tbl_addr;
        wdata_nxt   = tbl_data;
        wr_req_nxt  = 1'b1;
        cnt_nxt     = '0;
        in_host_nxt = 1'b0;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (spi.spi_done) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else if (timed_out) begin
          err_nxt     = 1'b1;
          err_idx_nxt = tbl_idx;
          state_nxt   = ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt != CNT_W'(SETTLE_CYC - 1)) begin
          cnt_nxt = cnt + 1'b1;
        end else if (in_host) begin
          state_nxt = IDLE;
`ifdef AD9122_CFG_VERIFY_EN
        end else begin
          state_nxt = VERIFY_ISSUE;
        end
`else
        end else if (last_entry) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = tbl_idx + 1'b1;
          state_nxt = ISSUE;
        end
`endif
      end
`ifdef AD9122_CFG_VERIFY_EN
      VERIFY_ISSUE: begin
        addr_nxt   = tbl_addr;
        rd_req_nxt = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = VERIFY_WAIT;
      end
      VERIFY_WAIT: begin
        if (spi.spi_done) begin
          if (spi.spi_rdata == tbl_data) begin
            retry_nxt = '0;
            if (last_entry) begin
              state_nxt = DONE;
            end else begin
              idx_nxt   = tbl_idx + 1'b1;
              state_nxt = ISSUE;
            end
          end else if (retry == RETRY_W'(MAX_RETRY)) begin
            err_nxt     = 1'b1;
            err_idx_nxt = tbl_idx;
            state_nxt   = ERR;
          end else begin
            retry_nxt = retry + 1'b1;
            state_nxt = ISSUE;       // rewrite the same entry
          end
        end else if (timed_out) begin
          err_nxt     = 1'b1;
          err_idx_nxt = tbl_idx;
          state_nxt   = ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      HOST_ISSUE: begin
        addr_nxt    = host_addr;
        wdata_nxt   = host_wdata;
        host_wr_nxt = host_wr;
        wr_req_nxt  = host_wr;
        rd_req_nxt  = !host_wr;
        cnt_nxt     = '0;
        in_host_nxt = 1'b1;
        state_nxt   = HOST_WAIT;
      end
      HOST_WAIT: begin
        if (spi.spi_done) begin
          if (!host_wr_q) rdata_nxt = spi.spi_rdata;
          ack_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else if (timed_out) begin
          err_nxt   = 1'b1;
          ack_nxt   = 1'b1;
          rdata_nxt = 8'h00;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        init_done_nxt = 1'b1;
        state_nxt     = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      tbl_idx        <= '0;
      in_host        <= 1'b0;
      host_wr_q      <= 1'b0;
      spi.spi_addr   <= 8'h00;
      spi.spi_wdata  <= 8'h00;
      spi.spi_wr_req <= 1'b0;
      spi.spi_rd_req <= 1'b0;
      host_ack       <= 1'b0;
      host_rdata     <= 8'h00;
      busy           <= 1'b0;
      init_done      <= 1'b0;
      err            <= 1'b0;
      err_idx        <= '0;
`ifdef AD9122_CFG_VERIFY_EN
      retry          <= '0;
`endif
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      tbl_idx        <= idx_nxt;
      in_host        <= in_host_nxt;
      host_wr_q      <= host_wr_nxt;
      spi.spi_addr   <= addr_nxt;
      spi.spi_wdata  <= wdata_nxt;
      spi.spi_wr_req <= wr_req_nxt;
      spi.spi_rd_req <= rd_req_nxt;
      host_ack       <= ack_nxt;
      host_rdata     <= rdata_nxt;
      busy           <= (state_nxt != IDLE);   // registered, so it tracks state exactly
      init_done      <= init_done_nxt;
      err            <= err_nxt;
      err_idx        <= err_idx_nxt;
`ifdef AD9122_CFG_VERIFY_EN
      retry          <= retry_nxt;
`endif
    end
  end

endmodule
